// File: rtl/mu_ring_node.sv
// Ring stop for motion-update migration traffic: buffers local packets, delivers
// ring packets addressed to this cell, forwards the rest with bounded ring streaks.
module mu_ring_node #(
  parameter int PKT_W        = 128,
  parameter int ID_W         = 5,
  parameter int LOCAL_ID     = 0,
  parameter int DEPTH        = 16,
  parameter int AFULL_MARGIN = 2,
  parameter int MAX_STREAK   = 4,
  parameter int CNT_W        = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PKT_W-1:0]         i_local_pkt,
  input  logic                     i_local_valid,
  output logic                     o_local_ready,
  input  logic [PKT_W-1:0]         i_ring_pkt,
  input  logic                     i_ring_valid,
  output logic                     o_ring_ready,
  output logic [PKT_W-1:0]         o_ring_pkt,
  output logic                     o_ring_valid,
  input  logic                     i_ring_ready,
  output logic [PKT_W-1:0]         o_deliver_pkt,
  output logic                     o_deliver_valid,
  output logic [$clog2(DEPTH):0]   o_fifo_count,
  output logic                     o_fifo_almost_full,
  output logic [CNT_W-1:0]         o_delivered_cnt,
  output logic [CNT_W-1:0]         o_injected_cnt,
  input  logic                     i_clear_cnt,
  output logic                     o_idle
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]   DEPTH_C      = CW'(DEPTH);
  localparam logic [CW-1:0]   AFULL_C      = CW'(DEPTH - AFULL_MARGIN);
  localparam logic [7:0]      STREAK_MAX_C = 8'(MAX_STREAK);
  localparam logic [ID_W-1:0] ID_C         = ID_W'(LOCAL_ID);

  logic [PKT_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [7:0]       r_streak;
  logic [PKT_W-1:0] r_ring_pkt;
  logic             r_ring_valid;
  logic [PKT_W-1:0] r_deliver_pkt;
  logic             r_deliver_valid;
  logic [CNT_W-1:0] r_delivered_cnt;
  logic [CNT_W-1:0] r_injected_cnt;

  logic             w_empty;
  logic [PKT_W-1:0] w_head;
  logic             w_out_free;
  logic             w_force_local;
  logic             w_ring_ready;
  logic             w_local_ready;
  logic             w_push;
  logic             w_ring_acc;
  logic             w_ring_local;
  logic             w_head_local;
  logic             w_pop;
  logic             w_ring_fwd;
  logic             w_ring_dlv;
  logic             w_head_fwd;
  logic             w_head_dlv;

  assign w_empty       = (r_count == '0);
  assign w_head        = r_mem[r_rd_ptr];
  assign w_out_free    = !r_ring_valid || i_ring_ready;
  assign w_force_local = (r_streak == STREAK_MAX_C) && !w_empty;
  assign w_ring_ready  = !w_force_local && w_out_free;
  assign w_local_ready = !rst && (r_count < DEPTH_C);
  assign w_push        = i_local_valid && w_local_ready;
  assign w_ring_acc    = i_ring_valid && w_ring_ready;
  assign w_ring_local  = (i_ring_pkt[PKT_W-1 -: ID_W] == ID_C);
  assign w_head_local  = (w_head[PKT_W-1 -: ID_W] == ID_C);

  // A self-addressed head bypasses the output register, so it may pop even
  // while the downstream link is stalled.
  assign w_pop = !w_empty && (!w_ring_acc || w_force_local) &&
                 (w_out_free || w_head_local);

  assign w_ring_fwd = w_ring_acc && !w_ring_local;
  assign w_ring_dlv = w_ring_acc && w_ring_local;
  assign w_head_fwd = w_pop && !w_head_local;
  assign w_head_dlv = w_pop && w_head_local;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_local_pkt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_streak <= '0;
    end else if (w_empty || w_pop) begin
      r_streak <= '0;
    end else if (w_ring_acc && (r_streak != STREAK_MAX_C)) begin
      r_streak <= r_streak + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ring_pkt   <= '0;
      r_ring_valid <= 1'b0;
    end else if (w_ring_fwd) begin
      r_ring_pkt   <= i_ring_pkt;
      r_ring_valid <= 1'b1;
    end else if (w_head_fwd) begin
      r_ring_pkt   <= w_head;
      r_ring_valid <= 1'b1;
    end else if (i_ring_ready) begin
      r_ring_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_deliver_pkt   <= '0;
      r_deliver_valid <= 1'b0;
    end else begin
      r_deliver_valid <= w_ring_dlv || w_head_dlv;
      if (w_ring_dlv) begin
        r_deliver_pkt <= i_ring_pkt;
      end else if (w_head_dlv) begin
        r_deliver_pkt <= w_head;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_clear_cnt) begin
      r_delivered_cnt <= '0;
      r_injected_cnt  <= '0;
    end else begin
      if (r_deliver_valid) begin
        r_delivered_cnt <= r_delivered_cnt + 1'b1;
      end
      if (w_head_fwd) begin
        r_injected_cnt <= r_injected_cnt + 1'b1;
      end
    end
  end

  assign o_local_ready      = w_local_ready;
  assign o_ring_ready       = w_ring_ready;
  assign o_ring_pkt         = r_ring_pkt;
  assign o_ring_valid       = r_ring_valid;
  assign o_deliver_pkt      = r_deliver_pkt;
  assign o_deliver_valid    = r_deliver_valid;
  assign o_fifo_count       = r_count;
  assign o_fifo_almost_full = (r_count >= AFULL_C);
  assign o_delivered_cnt    = r_delivered_cnt;
  assign o_injected_cnt     = r_injected_cnt;
  assign o_idle             = w_empty && !r_ring_valid && !i_ring_valid;

endmodule

// File: tb/tb_mu_ring_node.sv
// Directed bench for mu_ring_node (LOCAL_ID=5, ID_W=5, DEPTH=8, MAX_STREAK=3, PKT_W=32).
module tb_mu_ring_node;

  localparam int PKT_W = 32;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [PKT_W-1:0] i_local_pkt;
  logic             i_local_valid;
  logic             o_local_ready;
  logic [PKT_W-1:0] i_ring_pkt;
  logic             i_ring_valid;
  logic             o_ring_ready;
  logic [PKT_W-1:0] o_ring_pkt;
  logic             o_ring_valid;
  logic             i_ring_ready;
  logic [PKT_W-1:0] o_deliver_pkt;
  logic             o_deliver_valid;
  logic [3:0]       o_fifo_count;
  logic             o_fifo_almost_full;
  logic [CNT_W-1:0] o_delivered_cnt;
  logic [CNT_W-1:0] o_injected_cnt;
  logic             i_clear_cnt;
  logic             o_idle;

  int n_checks = 0;
  int n_errors = 0;

  mu_ring_node #(
    .PKT_W(PKT_W), .ID_W(5), .LOCAL_ID(5), .DEPTH(8),
    .AFULL_MARGIN(2), .MAX_STREAK(3), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .i_local_pkt(i_local_pkt), .i_local_valid(i_local_valid), .o_local_ready(o_local_ready),
    .i_ring_pkt(i_ring_pkt), .i_ring_valid(i_ring_valid), .o_ring_ready(o_ring_ready),
    .o_ring_pkt(o_ring_pkt), .o_ring_valid(o_ring_valid), .i_ring_ready(i_ring_ready),
    .o_deliver_pkt(o_deliver_pkt), .o_deliver_valid(o_deliver_valid),
    .o_fifo_count(o_fifo_count), .o_fifo_almost_full(o_fifo_almost_full),
    .o_delivered_cnt(o_delivered_cnt), .o_injected_cnt(o_injected_cnt),
    .i_clear_cnt(i_clear_cnt), .o_idle(o_idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PKT_W-1:0] mk(input logic [4:0] d, input int p);
    return {d, 27'(p)};
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [PKT_W-1:0] r_exp_out [7];
    logic             r_exp_rdy [7];
    logic [PKT_W-1:0] g [8];
    logic             acc;
    int               k;

    rst = 1'b1; i_local_pkt = '0; i_local_valid = 1'b0; i_ring_pkt = '0;
    i_ring_valid = 1'b0; i_ring_ready = 1'b1; i_clear_cnt = 1'b0;
    tick(); tick();
    check("rst_local_ready", o_local_ready, 0);
    check("rst_ring_valid", o_ring_valid, 0);
    check("rst_count", o_fifo_count, 0);
    check("rst_deliver_valid", o_deliver_valid, 0);
    rst = 1'b0;
    #1;
    check("post_rst_local_ready", o_local_ready, 1);
    check("post_rst_idle", o_idle, 1);

    // Ring delivery to this cell, then ring forwarding
    i_ring_pkt = mk(5, 'h111); i_ring_valid = 1'b1;
    #1 check("t1_ring_ready", o_ring_ready, 1);
    tick(); i_ring_valid = 1'b0;
    check("t1_dlv_valid", o_deliver_valid, 1);
    check("t1_dlv_pkt", o_deliver_pkt, mk(5, 'h111));
    check("t1_fwd_quiet", o_ring_valid, 0);
    tick();
    check("t1_dlv_pulse", o_deliver_valid, 0);
    check("t1_dlv_cnt", o_delivered_cnt, 1);
    i_ring_pkt = mk(9, 'h222); i_ring_valid = 1'b1;
    tick(); i_ring_valid = 1'b0;
    check("t1_fwd_valid", o_ring_valid, 1);
    check("t1_fwd_pkt", o_ring_pkt, mk(9, 'h222));
    check("t1_fwd_no_dlv", o_deliver_valid, 0);
    tick();
    check("t1_fwd_drop", o_ring_valid, 0);

    // Three local packets injected back to back
    i_local_valid = 1'b1; i_local_pkt = mk(9, 'h400);
    tick();
    check("t2_e1_valid", o_ring_valid, 0);
    check("t2_e1_count", o_fifo_count, 1);
    i_local_pkt = mk(9, 'h401);
    tick();
    check("t2_e2_pkt", o_ring_pkt, mk(9, 'h400));
    check("t2_e2_count", o_fifo_count, 1);
    i_local_pkt = mk(9, 'h402);
    tick(); i_local_valid = 1'b0;
    check("t2_e3_pkt", o_ring_pkt, mk(9, 'h401));
    tick();
    check("t2_e4_pkt", o_ring_pkt, mk(9, 'h402));
    check("t2_e4_valid", o_ring_valid, 1);
    check("t2_inj_cnt", o_injected_cnt, 3);
    tick();
    check("t2_drain", o_ring_valid, 0);
    check("t2_idle", o_idle, 1);

    // Ring streak limit forces one local injection
    for (int i = 0; i < 4; i++) r_exp_out[i] = mk(9, 'h300 + i);
    r_exp_out[4] = mk(9, 'h3AA);
    r_exp_out[5] = mk(9, 'h304);
    r_exp_out[6] = mk(9, 'h305);
    r_exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    k = 0;
    for (int c = 0; c < 7; c++) begin
      i_ring_valid = 1'b1; i_ring_pkt = mk(9, 'h300 + k);
      i_local_valid = (c == 0); i_local_pkt = mk(9, 'h3AA);
      #1;
      check($sformatf("t3_ready_c%0d", c), o_ring_ready, r_exp_rdy[c]);
      acc = o_ring_ready;
      tick();
      if (acc) k++;
      check($sformatf("t3_out_c%0d", c), o_ring_pkt, r_exp_out[c]);
      check($sformatf("t3_valid_c%0d", c), o_ring_valid, 1);
    end
    i_ring_valid = 1'b0; i_local_valid = 1'b0;
    tick(); tick();
    check("t3_inj_cnt", o_injected_cnt, 4);
    check("t3_idle", o_idle, 1);

    // Downstream stall with a self-addressed packet waiting upstream
    i_ring_pkt = mk(9, 'h600); i_ring_valid = 1'b1;
    tick();
    i_ring_ready = 1'b0; i_ring_pkt = mk(5, 'h601);
    for (int c = 0; c < 5; c++) begin
      #1 check($sformatf("t4_ready_c%0d", c), o_ring_ready, 0);
      tick();
      check($sformatf("t4_hold_c%0d", c), o_ring_pkt, mk(9, 'h600));
      check($sformatf("t4_hvalid_c%0d", c), o_ring_valid, 1);
      check($sformatf("t4_nodlv_c%0d", c), o_deliver_valid, 0);
    end
    i_ring_ready = 1'b1;
    #1 check("t4_release_ready", o_ring_ready, 1);
    tick(); i_ring_valid = 1'b0;
    check("t4_dlv_valid", o_deliver_valid, 1);
    check("t4_dlv_pkt", o_deliver_pkt, mk(5, 'h601));
    check("t4_fwd_consumed", o_ring_valid, 0);
    tick();
    check("t4_dlv_cnt", o_delivered_cnt, 2);
    check("t4_no_dup", o_ring_valid, 0);

    // Fill the FIFO while downstream stalls
    i_ring_pkt = mk(9, 'h700); i_ring_valid = 1'b1;
    tick(); i_ring_valid = 1'b0; i_ring_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      g[i] = mk(9, 'h500 + i);
      i_local_valid = 1'b1; i_local_pkt = g[i];
      #1;
      check($sformatf("t5_ready_%0d", i), o_local_ready, 1);
      check($sformatf("t5_afull_%0d", i), o_fifo_almost_full, (i >= 6));
      tick();
    end
    i_local_pkt = mk(9, 'h5FF);
    #1;
    check("t5_full_ready", o_local_ready, 0);
    check("t5_full_afull", o_fifo_almost_full, 1);
    check("t5_full_count", o_fifo_count, 8);
    tick(); i_local_valid = 1'b0;
    check("t5_ignored_count", o_fifo_count, 8);
    i_ring_ready = 1'b1;
    tick();
    check("t5_pop0_pkt", o_ring_pkt, g[0]);
    check("t5_pop0_count", o_fifo_count, 7);
    check("t5_pop0_ready", o_local_ready, 1);
    for (int i = 1; i < 8; i++) begin
      tick();
      check($sformatf("t5_pop%0d_pkt", i), o_ring_pkt, g[i]);
      check($sformatf("t5_pop%0d_valid", i), o_ring_valid, 1);
    end
    tick();
    check("t5_drain_valid", o_ring_valid, 0);
    check("t5_drain_count", o_fifo_count, 0);
    check("t5_inj_cnt", o_injected_cnt, 12);

    // Counter clear wins over a same-cycle delivery
    i_ring_pkt = mk(5, 'h800); i_ring_valid = 1'b1;
    tick(); i_ring_valid = 1'b0;
    check("t6_dlv_valid", o_deliver_valid, 1);
    i_clear_cnt = 1'b1;
    tick(); i_clear_cnt = 1'b0;
    check("t6_clr_dlv_cnt", o_delivered_cnt, 0);
    check("t6_clr_inj_cnt", o_injected_cnt, 0);
    tick();
    check("t6_stays_zero", o_delivered_cnt, 0);

    // Reset in the middle of traffic
    i_ring_pkt = mk(5, 'h900); i_ring_valid = 1'b1;
    i_local_pkt = mk(9, 'h901); i_local_valid = 1'b1;
    tick();
    i_ring_pkt = mk(9, 'h902); i_local_pkt = mk(9, 'h903);
    tick();
    check("t7_pre_dlv_cnt", o_delivered_cnt, 1);
    check("t7_pre_count", o_fifo_count, 2);
    check("t7_pre_ring_pkt", o_ring_pkt, mk(9, 'h902));
    rst = 1'b1;
    #1 check("t7_rst_local_ready", o_local_ready, 0);
    tick();
    i_ring_valid = 1'b0; i_local_valid = 1'b0;
    check("t7_rst_ring_valid", o_ring_valid, 0);
    check("t7_rst_ring_pkt", o_ring_pkt, 0);
    check("t7_rst_dlv_valid", o_deliver_valid, 0);
    check("t7_rst_count", o_fifo_count, 0);
    check("t7_rst_dlv_cnt", o_delivered_cnt, 0);
    check("t7_rst_afull", o_fifo_almost_full, 0);
    rst = 1'b0;
    #1;
    check("t7_post_local_ready", o_local_ready, 1);
    check("t7_post_idle", o_idle, 1);
    tick();
    check("t7_dropped", o_ring_valid, 0);
    check("t7_dropped_count", o_fifo_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
